// File: rtl/riscv_pkg.sv
// Shared writeback types: request payload and source id for the round-robin pointer.
package riscv_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_NUM_SRC = 2;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; push/pop are ignored when full/empty.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_req_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t pop_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [PW:0] wr_ptr, rd_ptr;
  entry_t      mem [DEPTH];
  logic        do_push, do_pop;

  assign empty_o    = (wr_ptr == rd_ptr);
  assign full_o     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU/LSU) driving the register-file write port.
// Optional WB_STATS_EN adds write / x0-drop / stall counters.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  wr_enable_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o
`ifdef WB_STATS_EN
  ,
  output logic [31:0]           stat_writes_o,
  output logic [31:0]           stat_x0_drops_o,
  output logic [31:0]           stat_stall_cycles_o
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  logic [WB_NUM_SRC-1:0] src_valid, src_ready, pop, full, empty;
  req_t [WB_NUM_SRC-1:0] src_req, head;

  assign src_valid = {lsu_valid_i, alu_valid_i};
  assign src_req   = {req_t'{addr: lsu_rd_i, data: lsu_data_i},
                      req_t'{addr: alu_rd_i, data: alu_data_i}};
  assign src_ready = ~full;
  assign alu_ready_o = src_ready[WB_SRC_ALU];
  assign lsu_ready_o = src_ready[WB_SRC_LSU];

  for (genvar s = 0; s < WB_NUM_SRC; s++) begin : g_src
    wb_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (req_t)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (src_valid[s]),
      .push_data_i (src_req[s]),
      .pop_i       (pop[s]),
      .pop_data_o  (head[s]),
      .full_o      (full[s]),
      .empty_o     (empty[s])
    );
  end

  wb_src_e last_grant, grant;
  logic    do_pop;
  req_t    sel;

  // On contention, the source that did not win last time goes first.
  always_comb begin
    grant  = WB_SRC_ALU;
    do_pop = 1'b0;
    if (!empty[WB_SRC_ALU] && !empty[WB_SRC_LSU]) begin
      do_pop = 1'b1;
      grant  = (last_grant == WB_SRC_LSU) ? WB_SRC_ALU : WB_SRC_LSU;
    end else if (!empty[WB_SRC_ALU]) begin
      do_pop = 1'b1;
      grant  = WB_SRC_ALU;
    end else if (!empty[WB_SRC_LSU]) begin
      do_pop = 1'b1;
      grant  = WB_SRC_LSU;
    end
    pop = '0;
    if (do_pop) pop[grant] = 1'b1;
    sel = head[grant];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_enable_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      last_grant  <= WB_SRC_LSU;
    end else begin
      // x0 entries still take the slot and advance the pointer, but never strobe.
      wr_enable_o <= do_pop && (sel.addr != '0);
      if (do_pop) begin
        wr_addr_o  <= sel.addr;
        wr_data_o  <= sel.data;
        last_grant <= grant;
      end
    end
  end

  assign busy_o = !empty[WB_SRC_ALU] || !empty[WB_SRC_LSU] || wr_enable_o;

`ifdef WB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_writes_o       <= '0;
      stat_x0_drops_o     <= '0;
      stat_stall_cycles_o <= '0;
    end else begin
      if (do_pop && (sel.addr != '0)) stat_writes_o   <= stat_writes_o + 32'd1;
      if (do_pop && (sel.addr == '0)) stat_x0_drops_o <= stat_x0_drops_o + 32'd1;
      if (|(src_valid & ~src_ready))  stat_stall_cycles_o <= stat_stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
